gamepad_pmod_tx: RTL and testbench
==================================

Name: gamepad_pmod_tx

Overview:
- Transmit side of the gamepad PMOD serial link (latch / clk / data): serialises a parallel button vector into the frame format that `gamepad_pmod_single` decodes.
- Used as a controller emulator in simulation and FPGA bring-up: drives `ui_in[6:4]` of the game top so flapping can be scripted without real hardware.
- Free-runs frames back-to-back while enabled, with a programmable gap between frames.

Parameters:
- CLK_DIV, 4: system clocks per half-period of pmod_clk; legal range ≥1.
- FRAME_GAP, 100: idle system clocks between the end of one frame and the next latch; legal range ≥1.
- NUM_PADS, 2: controllers per frame; legal values 1 or 2. Frame length NBITS = 12*NUM_PADS.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: high = send frames continuously; low = stop after the current frame.
- buttons, input, 12*NUM_PADS: 1 = pressed.
  - Pad p occupies [12p+11:12p].
  - Within a pad, bit order high→low is {b, y, select, start, up, down, left, right, a, x, l, r}.
- pmod_latch, output, 1: latch strobe, active high.
- pmod_clk, output, 1: shift clock; the receiver samples data on the rising edge.
- pmod_data, output, 1: serial data, MSB of the frame first.
- busy, output, 1: high from the first latch cycle through the last shift cycle.
- frame_done, output, 1: one-cycle pulse after the last bit.

Behaviour:
- Reset: every output (pmod_latch, pmod_clk, pmod_data, busy, frame_done) is 0; the state machine goes to IDLE; all counters clear. Reset has priority over all other activity and aborts a frame mid-operation, with outputs at 0 on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE, GAP.
- IDLE: enable sampled high → LATCH on the next edge, so pmod_latch and busy are 1 one cycle after enable is sampled.
- On entry to LATCH, buttons are captured into an NBITS shift register. Later changes to buttons are ignored until the next latch.
- LATCH:
  - pmod_latch = 1, pmod_clk = 0, pmod_data = 0, for 2*CLK_DIV cycles.
  - Then → SHIFT_LO with bit counter = 0.
- SHIFT_LO:
  - pmod_latch = 0, pmod_clk = 0, pmod_data = shift[NBITS-1], for CLK_DIV cycles.
  - Then → SHIFT_HI.
- SHIFT_HI:
  - pmod_clk = 1 and pmod_data held stable, for CLK_DIV cycles.
  - At exit: shift left by one and increment the bit counter.
  - If the counter has reached NBITS → DONE; otherwise → SHIFT_LO.
- Data therefore changes only while pmod_clk is low, which gives CLK_DIV cycles of setup and hold around each rising edge.
- Bit order on the wire:
  - buttons[NBITS-1] is sent first and buttons[0] last.
  - With NUM_PADS=2, pad 1 is sent first and pad 0 fills the last 12 bits, which is the pad a single-pad receiver keeps.
- DONE:
  - Lasts one cycle: frame_done = 1, busy = 0, pmod_clk = 0, pmod_data = 0.
  - Then → GAP if enable = 1, else → IDLE.
- GAP:
  - All lines low for FRAME_GAP cycles.
  - Then → LATCH if enable = 1, else → IDLE.
- Frame timing:
  - Total busy time = 2*CLK_DIV*(NBITS+1) cycles.
  - With the defaults: 8 latch + 24×8 shift = 200 cycles; frame_done arrives on cycle 201 after latch rise.
  - Latch-to-latch period when continuous = 2*CLK_DIV*(NBITS+1) + 1 + FRAME_GAP = 301 cycles with the defaults.
- enable deasserted mid-frame: the frame completes normally, including the frame_done pulse, then the block goes to IDLE.
- enable deasserted during GAP: the block goes to IDLE at the end of the gap; no partial latch is produced.
- Counter widths:
  - Bit counter: $clog2(NBITS+1).
  - Phase counter: wide enough for max(2*CLK_DIV, FRAME_GAP).
  - No counter ever wraps within a state.

Test Plan:
1. Reset held 5 cycles while enable = 1 → all outputs 0 throughout; after release, pmod_latch rises 1 cycle after enable is sampled and stays high 8 cycles (CLK_DIV = 4).
2. buttons = 24'hA5C_3F1, enable pulsed for 1 cycle → 24 rising pmod_clk edges; the sampled bit stream is 1010_0101_1100_0011_1111_0001; exactly one frame_done pulse, 200 cycles after latch rise; the block returns to IDLE.
3. enable held high → latch rising edges spaced exactly 301 cycles apart; buttons changed mid-frame appear only in the following frame.
4. Loopback into gamepad_pmod_single with pad 0 "up" pressed (buttons[7] = 1) → the receiver's up output = 1 and all other receiver button outputs = 0 after one frame.
5. enable dropped during bit 10 → the frame finishes all 24 bits with one frame_done pulse, and no further latch appears for 1000 cycles.
6. reset asserted in SHIFT_HI of bit 5 → pmod_clk, pmod_data and busy are 0 on the next edge; the next frame starts cleanly from LATCH and the full frame is correct.

Source files
------------

// File: rtl/gamepad_pmod_tx.sv
`default_nettype none
// ============================================================================
// Module   : gamepad_pmod_tx
// Purpose  : Gamepad PMOD link transmitter (latch / clk / data). Serialises a
//            parallel button vector, MSB first, into back-to-back frames with
//            a programmable idle gap between frames.
// Revision : 1.0 - initial release
// ============================================================================
module gamepad_pmod_tx #(
  parameter int CLK_DIV   = 4,    // system clocks per pmod_clk half-period
  parameter int FRAME_GAP = 100,  // idle clocks between frame_done and next latch
  parameter int NUM_PADS  = 2     // 1 or 2 controllers per frame
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [12*NUM_PADS-1:0]  buttons,
  output logic                    pmod_latch,
  output logic                    pmod_clk,
  output logic                    pmod_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int NBITS     = 12 * NUM_PADS;
  localparam int LATCH_LEN = 2 * CLK_DIV;
  localparam int PHASE_MAX = (LATCH_LEN > FRAME_GAP) ? LATCH_LEN : FRAME_GAP;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int BW        = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    phase, phase_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [NBITS-1:0] shift, shift_n;

  // Next-value versions of the outputs; registering them keeps every output
  // a flop with no path from enable/buttons.
  logic latch_n, clk_n, data_n, busy_n, done_n;

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      pmod_latch <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      pmod_latch <= latch_n;
      pmod_clk   <= clk_n;
      pmod_data  <= data_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Next-state, counter and shift-register logic. The phase counter restarts
  // at zero on every state change and counts the cycles spent in that state.
  always_comb begin
    state_n = state;
    phase_n = phase + PW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    unique case (state)
      IDLE: begin
        phase_n = '0;
        if (enable) begin
          state_n = LATCH;
          shift_n = buttons;
          bit_n   = '0;
        end
      end
      LATCH: begin
        if (phase == PW'(LATCH_LEN - 1)) begin
          state_n = SHIFT_LO;
          phase_n = '0;
          bit_n   = '0;
        end
      end
      SHIFT_LO: begin
        if (phase == PW'(CLK_DIV - 1)) begin
          state_n = SHIFT_HI;
          phase_n = '0;
        end
      end
      SHIFT_HI: begin
        if (phase == PW'(CLK_DIV - 1)) begin
          phase_n = '0;
          shift_n = {shift[NBITS-2:0], 1'b0};
          bit_n   = bit_cnt + BW'(1);
          state_n = (bit_cnt == BW'(NBITS - 1)) ? DONE : SHIFT_LO;
        end
      end
      DONE: begin
        phase_n = '0;
        state_n = enable ? GAP : IDLE;
      end
      GAP: begin
        if (phase == PW'(FRAME_GAP - 1)) begin
          phase_n = '0;
          if (enable) begin
            state_n = LATCH;
            shift_n = buttons;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
  end

  // Output values for the state being entered; data follows the MSB of the
  // shift register only while shifting, so it changes only with pmod_clk low.
  always_comb begin
    latch_n = (state_n == LATCH);
    clk_n   = (state_n == SHIFT_HI);
    data_n  = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? shift_n[NBITS-1] : 1'b0;
    busy_n  = (state_n == LATCH) || (state_n == SHIFT_LO) || (state_n == SHIFT_HI);
    done_n  = (state_n == DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_gamepad_pmod_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamepad_pmod_tx
// Purpose  : Scoreboard bench for gamepad_pmod_tx. Stimulus predicts each
//            frame (content and latch cycle); a monitor decodes the wire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamepad_pmod_tx;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_GAP = 100;
  localparam int NUM_PADS  = 2;
  localparam int NBITS     = 12 * NUM_PADS;
  localparam int BUSY_LEN  = 2 * CLK_DIV * (NBITS + 1);   // 200
  localparam int PERIOD    = BUSY_LEN + 1 + FRAME_GAP;    // 301

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [NBITS-1:0] buttons;
  logic             pmod_latch, pmod_clk, pmod_data, busy, frame_done;

  gamepad_pmod_tx #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_GAP (FRAME_GAP),
    .NUM_PADS  (NUM_PADS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .buttons    (buttons),
    .pmod_latch (pmod_latch),
    .pmod_clk   (pmod_clk),
    .pmod_data  (pmod_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle index: equals n after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NBITS-1:0] data;
    int               start;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   latch_rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic outs_zero(input string name);
    chk(name, {27'd0, pmod_latch, pmod_clk, pmod_data, busy, frame_done}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // One isolated frame: enable pulsed for one cycle; buttons scrambled after capture.
  task automatic single_frame(input logic [NBITS-1:0] v, input int pre_idle);
    exp_t e;
    repeat (pre_idle) tick();
    buttons = v;
    enable  = 1'b1;
    e.data  = v;
    e.start = cyc + 1;
    exp_q.push_back(e);
    tick();
    enable  = 1'b0;
    repeat (BUSY_LEN + 4) begin
      buttons = NBITS'($urandom);
      tick();
    end
  endtask

  // ---------------- monitor: decode the wire and score frames ----------------
  logic             prev_latch = 1'b0, prev_clk = 1'b0, prev_data = 1'b0, prev_done = 1'b0;
  logic [NBITS-1:0] word = '0;
  int               nclk = 0, latch_len = 0, busy_len = 0, cur_start = 0;
  bit               in_frame = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (pmod_latch && !prev_latch) begin
        latch_rises++;
        in_frame  = 1'b1;
        cur_start = cyc;
        word = '0; nclk = 0; latch_len = 0; busy_len = 0;
        if (exp_q.size() == 0) chk("unexpected_latch", 32'd1, 32'd0);
        else                   chk("latch_start_cycle", cyc, exp_q[0].start);
      end
      if (pmod_latch) latch_len++;
      if (busy) busy_len++;
      if (pmod_clk && !prev_clk) begin
        word = {word[NBITS-2:0], pmod_data};
        nclk++;
      end
      if (pmod_clk && prev_clk) chk("data_stable_clk_high", pmod_data, prev_data);
      if (frame_done && prev_done) chk("done_single_pulse", 32'd1, 32'd0);
      if (frame_done && !prev_done) begin
        if (!in_frame || exp_q.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data",    word, e.data);
          chk("done_latency",  cyc - cur_start, BUSY_LEN);
          chk("latch_len",     latch_len, 2 * CLK_DIV);
          chk("clk_edges",     nclk, NBITS);
          chk("busy_len",      busy_len, BUSY_LEN);
          chk("busy_at_done",  busy, 1'b0);
        end
        in_frame = 1'b0;
      end
    end
    prev_latch = pmod_latch;
    prev_clk   = pmod_clk;
    prev_data  = pmod_data;
    prev_done  = frame_done;
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    int   s0, rises;

    // Reset held with enable high: outputs stay low.
    reset   = 1'b1;
    enable  = 1'b1;
    buttons = 24'hA5C3F1;
    repeat (5) begin
      tick();
      outs_zero("reset_outputs");
    end

    // Release reset with enable still high: latch one cycle later.
    reset   = 1'b0;
    e.data  = buttons;
    e.start = cyc + 1;
    exp_q.push_back(e);
    tick();
    enable = 1'b0;
    repeat (BUSY_LEN + 4) begin
      buttons = NBITS'($urandom);
      tick();
    end
    outs_zero("idle_after_frame");

    // Directed patterns: reference vector, pad 0 "up" alone, extremes.
    single_frame(24'hA5C3F1, 3);
    single_frame(24'h000080, 0);
    single_frame(24'hFFFFFF, 1);
    single_frame(24'h000000, 2);

    // Random isolated frames.
    for (int i = 0; i < 6; i++)
      single_frame(NBITS'($urandom), int'($urandom_range(0, 15)));

    // Continuous frames: each frame captures the value present at its latch
    // edge; buttons are scrambled in between. Enable drops during bit 10 of
    // the third frame.
    tick();
    enable = 1'b1;
    s0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      wait_until(s0 + i * PERIOD - 1);
      buttons = NBITS'($urandom);
      e.data  = buttons;
      e.start = s0 + i * PERIOD;
      exp_q.push_back(e);
      tick();
      buttons = NBITS'($urandom);
    end
    wait_until(s0 + 2 * PERIOD + 2 * CLK_DIV + 10 * 2 * CLK_DIV + 3);
    enable = 1'b0;
    wait_until(s0 + 2 * PERIOD + BUSY_LEN + 2);
    rises = latch_rises;
    repeat (1000) begin
      buttons = NBITS'($urandom);
      tick();
    end
    chk("no_latch_after_disable", latch_rises, rises);
    chk("queue_drained_cont", exp_q.size(), 0);

    // Reset during SHIFT_HI of bit 5 aborts the frame.
    buttons = NBITS'($urandom);
    enable  = 1'b1;
    s0 = cyc + 1;
    e.data  = buttons;
    e.start = s0;
    exp_q.push_back(e);
    tick();
    enable = 1'b0;
    wait_until(s0 + 2 * CLK_DIV + 5 * 2 * CLK_DIV + CLK_DIV);
    chk("in_shift_hi", pmod_clk, 1'b1);
    reset = 1'b1;
    void'(exp_q.pop_front());
    tick();
    outs_zero("abort_outputs");
    tick();
    outs_zero("abort_outputs_hold");
    reset = 1'b0;
    single_frame(NBITS'($urandom), 2);
    single_frame(24'h5A5A5A, 0);

    chk("queue_drained_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #(10 * 20000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
